// File: rtl/pio_decode_stage.sv
// Decode/sequencing stage for one PIO state machine: latches an instruction, splits out
// opcode, operands, side-set and delay, then holds fetch off until execution and delay finish.
module pio_decode_stage #(
  parameter int unsigned FIELD_W = 5,
  parameter int unsigned CNT_W   = $clog2(FIELD_W + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                restart,
  input  logic [CNT_W-1:0]    sideset_bits,
  input  logic                sideset_opt,
  input  logic                sideset_pindirs,
  input  logic                in_valid,
  input  logic [FIELD_W+10:0] instr,
  output logic                in_ready,
  input  logic                exec_stall,
  output logic                out_valid,
  output logic [2:0]          op,
  output logic [2:0]          op1,
  output logic [4:0]          op2,
  output logic [FIELD_W-1:0]  side_set,
  output logic                side_set_valid,
  output logic                side_set_pindirs,
  output logic                delay_active,
  output logic [FIELD_W-1:0]  delay_remaining
);

  localparam int unsigned IW = FIELD_W + 11;
  localparam logic [CNT_W:0] FieldWC = (CNT_W + 1)'(FIELD_W);

  typedef enum logic [1:0] {StIdle, StExec, StDelay} state_e;

  state_e             r_state, w_state_next;
  logic [IW-1:0]      r_instr, w_instr_next;
  logic [CNT_W-1:0]   r_bits, w_bits_next;
  logic               r_opt, w_opt_next;
  logic               r_pdir, w_pdir_next;
  logic [FIELD_W-1:0] r_cnt, w_cnt_next;
  logic               r_strobe, w_strobe_next;
  logic               r_armed;

  logic [FIELD_W-1:0] w_field, w_delay, w_side;
  logic [CNT_W:0]     w_sum, w_b, w_t;
  logic               w_en_ss, w_exec, w_dly, w_complete, w_accept;

  // Field decode from the latched configuration; B is clamped so opt + B fits the field.
  always_comb begin
    w_field = r_instr[FIELD_W+7:8];
    w_sum   = {1'b0, r_bits} + {{CNT_W{1'b0}}, r_opt};
    w_b     = (w_sum > FieldWC) ? (FieldWC - {{CNT_W{1'b0}}, r_opt}) : {1'b0, r_bits};
    w_t     = w_b + {{CNT_W{1'b0}}, r_opt};
    w_delay = ({FIELD_W{1'b1}} >> w_t) & w_field;
    w_side  = (w_field >> (FieldWC - w_t)) & ~({FIELD_W{1'b1}} << w_b);
    w_en_ss = (w_b != '0) && (!r_opt || w_field[FIELD_W-1]);
  end

  always_comb begin
    w_exec     = (r_state == StExec);
    w_dly      = (r_state == StDelay);
    w_complete = en && !restart &&
                 ((w_exec && !exec_stall && (w_delay == '0)) ||
                  (w_dly && (r_cnt == FIELD_W'(1))));
    in_ready   = r_armed && en && !restart && ((r_state == StIdle) || w_complete);
    w_accept   = in_ready && in_valid;

    w_state_next  = r_state;
    w_instr_next  = r_instr;
    w_bits_next   = r_bits;
    w_opt_next    = r_opt;
    w_pdir_next   = r_pdir;
    w_cnt_next    = r_cnt;
    w_strobe_next = r_strobe;

    if (restart) begin
      w_state_next  = StIdle;
      w_instr_next  = '0;
      w_bits_next   = '0;
      w_opt_next    = 1'b0;
      w_pdir_next   = 1'b0;
      w_cnt_next    = '0;
      w_strobe_next = 1'b0;
    end else if (en) begin
      unique case (r_state)
        StIdle: ;
        StExec: begin
          w_strobe_next = 1'b0;
          if (!exec_stall && (w_delay != '0)) begin
            w_cnt_next   = w_delay;
            w_state_next = StDelay;
          end else if (!exec_stall) begin
            w_state_next = StIdle;
          end
        end
        StDelay: begin
          w_cnt_next = r_cnt - FIELD_W'(1);
          if (r_cnt == FIELD_W'(1)) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
      if (w_accept) begin
        w_state_next  = StExec;
        w_instr_next  = instr;
        w_bits_next   = sideset_bits;
        w_opt_next    = sideset_opt;
        w_pdir_next   = sideset_pindirs;
        w_strobe_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_instr  <= '0;
      r_bits   <= '0;
      r_opt    <= 1'b0;
      r_pdir   <= 1'b0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_instr  <= w_instr_next;
      r_bits   <= w_bits_next;
      r_opt    <= w_opt_next;
      r_pdir   <= w_pdir_next;
      r_cnt    <= w_cnt_next;
      r_strobe <= w_strobe_next;
      r_armed  <= 1'b1;
    end
  end

  // The side-set strobe stays pending until an enabled EXEC cycle consumes it.
  always_comb begin
    out_valid        = w_exec;
    op               = r_instr[IW-1:IW-3];
    op1              = r_instr[7:5];
    op2              = r_instr[4:0];
    side_set         = w_side;
    side_set_valid   = w_exec && r_strobe && w_en_ss && !restart;
    side_set_pindirs = r_pdir;
    delay_active     = w_dly;
    delay_remaining  = r_cnt;
  end

endmodule

// File: doc/pio_decode_stage.md
Name: pio_decode_stage

Overview:
- Registered decode/sequencing stage for one PIO state machine, between instruction fetch and execute.
- Accepts one instruction per valid/ready handshake and splits it into opcode/operand fields.
- Extracts side-set and delay using a parametrised delay/side-set field width, supporting optional side-set and pindirs mode.
- Runs the post-instruction delay counter and back-pressures fetch until the instruction and its delay have completed.

Parameters:
- FIELD_W, 5: width of the delay/side-set field. Instruction width is FIELD_W+11: op at the top 3 bits, field at [FIELD_W+7:8], op1 at [7:5], op2 at [4:0].
- CNT_W, $clog2(FIELD_W+1): width of side-set count configuration.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  clock-divider enable; state advances only when 1.
- restart  in  1  synchronous flush.
- sideset_bits  in  CNT_W  side-set bit count, excluding the opt bit.
- sideset_opt  in  1  MSB of field is the side-set enable bit.
- sideset_pindirs  in  1  side-set drives pin directions.
- in_valid  in  1  fetch has an instruction.
- instr  in  FIELD_W+11  instruction word.
- in_ready  out  1  instruction accepted this cycle when in_valid=1.
- exec_stall  in  1  execute unit: current instruction not complete (wait/blocking).
- out_valid  out  1  held instruction present (EXEC state).
- op  out  3  opcode.
- op1  out  3  operand 1.
- op2  out  5  operand 2.
- side_set  out  FIELD_W  side-set value, right-justified.
- side_set_valid  out  1  one-cycle strobe: apply side_set.
- side_set_pindirs  out  1  latched sideset_pindirs.
- delay_active  out  1  in DELAY state.
- delay_remaining  out  FIELD_W  delay cycles left.

Behaviour:
- Reset (reset_n=0, async): state IDLE, instruction register 0, counter 0. All outputs are 0, including in_ready. in_ready may rise only after the first clk edge with reset_n=1.
- Acceptance: on accept, instr, sideset_bits, sideset_opt and sideset_pindirs are latched. Configuration changes do not affect the held instruction.
- Clamp: if sideset_bits+sideset_opt > FIELD_W, the effective bits are B = FIELD_W-sideset_opt; otherwise B = sideset_bits. Total T = B+sideset_opt.
- delay = field[FIELD_W-T-1:0], zero-extended. delay = 0 when T = FIELD_W.
- side_set = field[FIELD_W-1-opt -: B], right-justified with zero upper bits. side_set = 0 when B = 0.
- Side-set enable: en_ss = B>0 and (opt ? field[FIELD_W-1] : 1).
- States:
  - IDLE: in_ready=en. On en && in_valid → EXEC.
  - EXEC: out_valid=1. side_set_valid=en_ss on the first cycle in EXEC only, regardless of exec_stall.
    - On en && !exec_stall with delay=0: complete. in_ready=1 that cycle; if in_valid, stay in EXEC with the new instruction (new side-set strobe next cycle), else → IDLE.
    - On en && !exec_stall with delay>0: counter ← delay → DELAY.
  - DELAY: delay_active=1, delay_remaining=counter. Counter decrements each en cycle.
    - When counter=1 && en: complete. in_ready=1; accept → EXEC, else → IDLE.
    - The instruction therefore occupies exactly delay enabled cycles after its completion cycle.
- en=0: state, counter and fields are frozen; in_ready=0. A pending side_set_valid strobe is held until the first en=1 cycle.
- restart: highest priority below reset. Next state IDLE, counter 0, side_set_valid 0, no acceptance that cycle (in_ready=0).
- exec_stall is ignored outside EXEC. Stall cycles never consume delay.
- Latency: instruction accepted at edge N → fields and strobe visible in cycle N+1. Back-to-back delay-0, unstalled instructions sustain 1 per cycle.
- Counter width FIELD_W; it never wraps because it is loaded only with a nonzero delay ≤ 2^FIELD_W-1.

Test Plan:
- sideset_bits=2, opt=1, instr=0x1B25, en=1 → op=0, op1=1, op2=5, side_set=2, side_set_valid one cycle, delay_remaining 3,2,1; next instruction accepted 4 cycles after EXEC entry.
- As above with instr=0x0B25 → side_set=2, side_set_valid=0, delay still 3.
- sideset_bits=0, opt=0, field=0x04, exec_stall high 4 cycles → EXEC for 5 cycles, side_set_valid=0, DELAY 4 cycles, in_ready on the 4th DELAY cycle.
- Three back-to-back delay-0 instructions, in_valid held high → in_ready high continuously, out_valid high 3 cycles, op follows each word.
- sideset_bits=7, opt=1 (clamp B=4), field=0x1F → side_set=0xF, delay=0, valid=1. en toggled 1/0 during a delay of 3 → DELAY lasts 3 enabled cycles.
- restart mid-DELAY, and reset_n low mid-EXEC → IDLE, all outputs 0, next instruction decodes normally.
